// File: rtl/coverfloat_vector_packer.sv
// coverfloat_vector_packer
//   Writer side of the cover-vector format. One FPU transaction is captured
//   per in_valid/in_ready handshake, packed MSB-first in the same field
//   order the coverage reader unpacks, buffered in a DEPTH-record FIFO and
//   streamed to a trace sink as NBEATS beats of BEAT_W bits each.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_ready transaction handshake (in_ready = FIFO not full)
//   op .. exceptionBits transaction fields, sampled at the push edge
//   out_valid/out_ready beat handshake towards the trace sink
//   out_data          current beat, out_beat its index, out_last final beat
//   vec_count         records fully emitted (wraps at 2^32)
//   fifo_level        records still in the FIFO (excludes the one in flight)
module coverfloat_vector_packer #(
  parameter int OP_W   = 32,
  parameter int RM_W   = 8,
  parameter int OPND_W = 128,
  parameter int FMT_W  = 8,
  parameter int INTX_W = 32,
  parameter int INTM_W = 192,
  parameter int EXC_W  = 8,
  parameter int BEAT_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_W-1:0]            op,
  input  logic [RM_W-1:0]            rm,
  input  logic [OPND_W-1:0]          a,
  input  logic [OPND_W-1:0]          b,
  input  logic [OPND_W-1:0]          c,
  input  logic [FMT_W-1:0]           aFmt,
  input  logic [FMT_W-1:0]           bFmt,
  input  logic [FMT_W-1:0]           cFmt,
  input  logic [OPND_W-1:0]          result,
  input  logic [FMT_W-1:0]           resultFmt,
  input  logic                       intermS,
  input  logic [INTX_W-1:0]          intermX,
  input  logic [INTM_W-1:0]          intermM,
  input  logic [EXC_W-1:0]           exceptionBits,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BEAT_W-1:0]          out_data,
  output logic                       out_last,
  output logic [7:0]                 out_beat,
  output logic [31:0]                vec_count,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int VEC_W  = OP_W + RM_W + 4*OPND_W + 4*FMT_W + 1 + INTX_W + INTM_W + EXC_W;
  localparam int NBEATS = (VEC_W + BEAT_W - 1) / BEAT_W;
  localparam int SH_W   = NBEATS * BEAT_W;
  localparam int PAD    = SH_W - VEC_W;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t             r_state;
  logic [VEC_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;
  logic               r_in_ready;
  logic [SH_W-1:0]    r_shift;
  logic [7:0]         r_beat;
  logic               r_out_valid;
  logic               r_out_last;
  logic [31:0]        r_vec_count;

  logic [VEC_W-1:0]   w_vec;
  logic [SH_W-1:0]    w_head;
  logic               w_push;
  logic               w_fire;
  logic               w_last_fire;
  logic               w_nonempty;
  logic               w_pop;
  logic [CW-1:0]      w_count_nxt;

  assign w_vec = {op, rm, a, b, c, aFmt, bFmt, cFmt, result, resultFmt,
                  intermS, intermX, intermM, exceptionBits};

  // Head record left-aligned in the shift register; padding lands on the LSB side.
  assign w_head = SH_W'(r_mem[r_rptr]) << PAD;

  assign w_push      = in_valid && r_in_ready;
  assign w_fire      = r_out_valid && out_ready;
  assign w_last_fire = w_fire && r_out_last;
  assign w_nonempty  = (r_count != '0);
  // Pop when idle, or on the final beat handshake so the next record follows with no bubble.
  assign w_pop       = w_nonempty && ((r_state == S_IDLE) || w_last_fire);
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b0;
      r_shift     <= '0;
      r_beat      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_vec_count <= '0;
    end else begin
      r_count    <= w_count_nxt;
      // Registered from the next count so in_ready always matches the current fill.
      r_in_ready <= (w_count_nxt != CW'(DEPTH));

      if (w_push) begin
        r_mem[r_wptr] <= w_vec;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift     <= w_head;
            r_beat      <= '0;
            r_out_valid <= 1'b1;
            r_out_last  <= (NBEATS == 1);
            r_state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_fire) begin
            if (r_out_last) begin
              r_vec_count <= r_vec_count + 32'd1;
              if (w_pop) begin
                r_shift     <= w_head;
                r_beat      <= '0;
                r_out_valid <= 1'b1;
                r_out_last  <= (NBEATS == 1);
              end else begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_state     <= S_IDLE;
              end
            end else begin
              r_shift    <= r_shift << BEAT_W;
              r_beat     <= r_beat + 8'd1;
              r_out_last <= (r_beat == 8'(NBEATS - 2));
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign out_beat   = r_beat;
  assign out_data   = r_shift[SH_W-1 -: BEAT_W];
  assign vec_count  = r_vec_count;
  assign fifo_level = r_count;

endmodule

// File: tb/tb_coverfloat_vector_packer.sv
// Self-checking bench for coverfloat_vector_packer: directed scenarios plus
// randomized traffic checked against a queue-of-records reference model.
module tb_coverfloat_vector_packer;

  localparam int NB    = 26;
  localparam int REC_W = NB * 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   op = '0;
  logic [7:0]    rm = '0;
  logic [127:0]  a = '0, b = '0, c = '0, result = '0;
  logic [7:0]    aFmt = '0, bFmt = '0, cFmt = '0, resultFmt = '0;
  logic          intermS = 1'b0;
  logic [31:0]   intermX = '0;
  logic [191:0]  intermM = '0;
  logic [7:0]    exceptionBits = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic          out_last;
  logic [7:0]    out_beat;
  logic [31:0]   vec_count;
  logic [2:0]    fifo_level;

  coverfloat_vector_packer #(.DEPTH(4), .BEAT_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rm(rm), .a(a), .b(b), .c(c),
    .aFmt(aFmt), .bFmt(bFmt), .cFmt(cFmt),
    .result(result), .resultFmt(resultFmt),
    .intermS(intermS), .intermX(intermX), .intermM(intermM),
    .exceptionBits(exceptionBits),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_beat(out_beat),
    .vec_count(vec_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: each accepted transaction becomes one 832-bit record
  // (817 field bits left-aligned, zero padding below); beats are sliced from it.
  function automatic logic [REC_W-1:0] pack_cur();
    return {op, rm, a, b, c, aFmt, bFmt, cFmt, result, resultFmt,
            intermS, intermX, intermM, exceptionBits, 15'd0};
  endfunction

  logic [REC_W-1:0] exp_q[$];
  int               exp_beat = 0;
  logic [31:0]      mvec = '0;
  bit               held_v = 0;
  logic [31:0]      held_d;
  logic [7:0]       held_b;
  logic [31:0]      obs [NB];
  logic             obs_last [NB];
  int               hs_cnt = 0;
  int               stray = 0;
  bit               rnd_ready = 0;

  always @(negedge clk) begin
    logic [REC_W-1:0] rec;
    logic [31:0]      exp_d;
    if (reset) begin
      exp_q.delete();
      exp_beat = 0;
      held_v   = 0;
      mvec     = '0;
    end else begin
      chk("vec_count", vec_count, mvec);
      if (held_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, held_d);
        chk("hold_beat", out_beat, held_b);
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_b = out_beat;
      if (out_valid) stray++;
      else chk("last_idle", out_last, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", out_valid, 0);
        end else begin
          rec   = exp_q[0];
          exp_d = rec[REC_W-1-32*exp_beat -: 32];
          chk("beat_data", out_data, exp_d);
          chk("beat_idx", out_beat, exp_beat);
          chk("beat_last", out_last, exp_beat == NB-1);
          obs[exp_beat]      = out_data;
          obs_last[exp_beat] = out_last;
          hs_cnt++;
          if (exp_beat == NB-1) begin
            exp_beat = 0;
            void'(exp_q.pop_front());
            mvec = mvec + 32'd1;
          end else begin
            exp_beat++;
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(pack_cur());
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_random();
    op = $urandom(); rm = 8'($urandom());
    a = {$urandom(), $urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    c = {$urandom(), $urandom(), $urandom(), $urandom()};
    result = {$urandom(), $urandom(), $urandom(), $urandom()};
    aFmt = 8'($urandom()); bFmt = 8'($urandom()); cFmt = 8'($urandom());
    resultFmt = 8'($urandom()); intermS = 1'($urandom());
    intermX = $urandom();
    intermM = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    exceptionBits = 8'($urandom());
  endtask

  // Called just after a rising edge; returns just after the edge that took the push.
  task automatic push_try(input int max_cyc, output bit ok);
    ok = 0;
    in_valid = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push_rand();
    bit ok;
    set_random();
    push_try(300, ok);
    chk("push_accepted", ok, 1);
  endtask

  task automatic wait_beat(input int k);
    bit found = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (out_valid && out_beat == 8'(k)) begin
        found = 1;
        break;
      end
    end
    chk("wait_beat", found, 1);
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        done = 1;
        break;
      end
    end
    chk("drain", done, 1);
    tick();
  endtask

  initial begin
    bit ok;
    int acc;
    int hs0;
    logic [2:0] lvl;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_beat", out_beat, 0);
    chk("rst_vec_count", vec_count, 0);
    chk("rst_fifo_level", fifo_level, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // Single known record
    out_ready = 1'b1;
    op = 32'h1; a = {16{8'hAA}}; b = a; c = a; exceptionBits = 8'h1F;
    hs0 = hs_cnt;
    push_try(50, ok);
    chk("single_push", ok, 1);
    drain();
    chk("single_beats", hs_cnt - hs0, NB);
    chk("single_b0", obs[0], 32'h0000_0001);
    chk("single_b1", obs[1], 32'h00AA_AAAA);
    chk("single_b25", obs[25], 32'h000F_8000);
    chk("single_b25_last", obs_last[25], 1);
    chk("single_vec", vec_count, 1);
    chk("single_valid_after", out_valid, 0);

    // Back-pressure 1,0,0,1 around beats 3-5
    hs0 = hs_cnt;
    push_rand();
    wait_beat(3);
    tick(); out_ready = 1'b0;
    tick();
    tick(); out_ready = 1'b1;
    drain();
    chk("bp_beats", hs_cnt - hs0, NB);

    // FIFO full with sink stalled
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      set_random();
      push_try(20, ok);
      if (ok) acc++;
      if (i == 3) chk("full_level3", fifo_level, 3);
    end
    @(negedge clk);
    chk("full_accepted", acc, 5);
    chk("full_level4", fifo_level, 4);
    chk("full_in_ready", in_ready, 0);
    tick();
    out_ready = 1'b1;
    drain();
    chk("full_vec", vec_count, 7);

    // Push coinciding with the final-beat handshake
    out_ready = 1'b0;
    push_rand();
    push_rand();
    tick();
    out_ready = 1'b1;
    wait_beat(24);
    tick();
    set_random();
    in_valid = 1'b1;
    @(negedge clk);
    chk("sim_last", out_last, 1);
    chk("sim_in_ready", in_ready, 1);
    lvl = fifo_level;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("sim_level", fifo_level, lvl);
    chk("sim_valid", out_valid, 1);
    chk("sim_beat0", out_beat, 0);
    tick();
    drain();

    // Reset in the middle of a record
    out_ready = 1'b0;
    push_rand(); push_rand(); push_rand();
    out_ready = 1'b1;
    wait_beat(10);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_vec", vec_count, 0);
    chk("mid_rst_level", fifo_level, 0);
    reset = 1'b0;
    stray = 0;
    repeat (40) tick();
    chk("mid_rst_no_stray", stray, 0);

    // vec_count wrap
    force dut.r_vec_count = 32'hFFFF_FFFF;
    mvec = 32'hFFFF_FFFF;
    tick();
    release dut.r_vec_count;
    tick();
    push_rand();
    drain();
    chk("wrap_vec", vec_count, 0);

    // Randomized traffic
    rnd_ready = 1;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      push_rand();
    end
    drain();
    rnd_ready = 0;
    #2;
    out_ready = 1'b1;
    tick();
    chk("rand_vec", vec_count, 30);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
